reg_port_ctrl: RTL and testbench

Initiator-side controller for the 32×32 register bank (posedge write port, negedge-sampled read port). It accepts operand-fetch requests from decode over a valid/ready handshake and drives the bank's read port. It returns both operands downstream and drives the bank's write port from the writeback stage. A 32-entry busy scoreboard stalls any fetch that would read, or re-target, a register with a write still in flight.

---
 rtl/reg_port_ctrl_pkg.sv | 27 ++
 rtl/reg_port_ctrl_if.sv | 48 ++++
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/reg_port_ctrl.sv | 136 +++++++++++++
 tb/tb_reg_port_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_port_ctrl_pkg.sv
// reg_port_ctrl_pkg: sizes, FSM encoding and helpers shared by
// the register-port controller, its scoreboard and its interface.
package reg_port_ctrl_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [NREG-1:0] dec(
    input logic          en,
    input logic [AW-1:0] a
  );
    logic [NREG-1:0] v;
    v = '0;
    if (en) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_port_ctrl_if.sv
// reg_port_ctrl_if: fetch request, operand, writeback and bank
// port signals of the register-port controller.
interface reg_port_ctrl_if;
  import reg_port_ctrl_pkg::*;

  logic          rq_valid;
  logic          rq_ready;
  logic [AW-1:0] rq_rs;
  logic [AW-1:0] rq_rt;
  logic [AW-1:0] rq_rd;
  logic          rq_wb;

  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [AW-1:0] op_rd;

  logic          wb_valid;
  logic [AW-1:0] wb_dir;
  logic [DW-1:0] wb_data;

  logic [AW-1:0] dir_a;
  logic [AW-1:0] dir_b;
  logic          reg_rd;
  logic [AW-1:0] dir_wra;
  logic [DW-1:0] di;
  logic          reg_wr;
  logic [DW-1:0] doa;
  logic [DW-1:0] dob;

  modport slave (
    input  rq_valid, rq_rs, rq_rt, rq_rd, rq_wb,
    input  op_ready, wb_valid, wb_dir, wb_data,
    input  doa, dob,
    output rq_ready, op_valid, op_a, op_b, op_rd,
    output dir_a, dir_b, reg_rd, dir_wra, di, reg_wr
  );

  modport master (
    output rq_valid, rq_rs, rq_rt, rq_rd, rq_wb,
    output op_ready, wb_valid, wb_dir, wb_data,
    output doa, dob,
    input  rq_ready, op_valid, op_a, op_b, op_rd,
    input  dir_a, dir_b, reg_rd, dir_wra, di, reg_wr
  );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: write-in-flight bit per register and fetch hazard.
// Build option WB_BYPASS_EN: a bit clearing on this edge reads as free.
module reg_scoreboard
  import reg_port_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
`ifdef WB_BYPASS_EN
  input  logic          i_byp_en,
`endif
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_rt,
  input  logic [AW-1:0] i_rd,
  input  logic          i_rd_wb,
  output logic          o_hazard
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_view;

  assign w_set = dec(i_set_en, i_set_addr);
  assign w_clr = dec(i_clr_en, i_clr_addr);

`ifdef WB_BYPASS_EN
  assign w_view = r_busy & ~(i_byp_en ? w_clr : '0);
`else
  assign w_view = r_busy;
`endif

  assign o_hazard = w_view[i_rs] | w_view[i_rt]
                  | (i_rd_wb & w_view[i_rd]);

  // clear beats set; bit 0 is pinned free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= ((r_busy | w_set) & ~w_clr)
                        & {{(NREG-1){1'b1}}, 1'b0};
  end

endmodule

// File: rtl/reg_port_ctrl.sv
// reg_port_ctrl: operand-fetch controller for a 32x32 register bank.
// Build option WB_BYPASS_EN: landing writeback releases stalls a cycle early.
module reg_port_ctrl
  import reg_port_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_port_ctrl_if.slave bus
);

  state_t        r_state;
  state_t        w_next;
  logic          w_hazard;
  logic          w_ready;
  logic          w_accept;
  logic          w_cap;
  logic          w_drop;
  logic          w_set;
  logic          w_wb;

  logic [AW-1:0] r_dir_a;
  logic [AW-1:0] r_dir_b;
  logic [AW-1:0] r_op_rd;
  logic [AW-1:0] r_dir_wra;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic [DW-1:0] r_di;
  logic          r_reg_rd;
  logic          r_op_valid;
  logic          r_reg_wr;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_cap   = 1'b0;
    w_drop  = 1'b0;
    unique case (r_state)
      IDLE: w_ready = !w_hazard;
      READ: begin
        w_cap  = 1'b1;
        w_next = HOLD;
      end
      HOLD: if (bus.op_ready) begin
        w_drop  = 1'b1;
        w_ready = !w_hazard;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_accept = w_ready & bus.rq_valid;
    if (w_accept) w_next = READ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  assign w_set = w_accept & bus.rq_wb
               & (bus.rq_rd != ZERO_REG);
  assign w_wb  = bus.wb_valid
               & (bus.wb_dir != ZERO_REG);

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_set),
    .i_set_addr (bus.rq_rd),
    .i_clr_en   (r_reg_wr),
    .i_clr_addr (r_dir_wra),
`ifdef WB_BYPASS_EN
    .i_byp_en   (r_reg_wr),
`endif
    .i_rs       (bus.rq_rs),
    .i_rt       (bus.rq_rt),
    .i_rd       (bus.rq_rd),
    .i_rd_wb    (bus.rq_wb),
    .o_hazard   (w_hazard)
  );

  // bank data is valid here: it was sampled on the negedge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir_a    <= '0;
      r_dir_b    <= '0;
      r_op_rd    <= '0;
      r_reg_rd   <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dir_a  <= bus.rq_rs;
        r_dir_b  <= bus.rq_rt;
        r_op_rd  <= bus.rq_rd;
        r_reg_rd <= 1'b1;
      end else if (w_cap) begin
        r_reg_rd <= 1'b0;
      end
      if (w_cap) begin
        r_op_a     <= (r_dir_a == ZERO_REG) ? '0 : bus.doa;
        r_op_b     <= (r_dir_b == ZERO_REG) ? '0 : bus.dob;
        r_op_valid <= 1'b1;
      end else if (w_drop) begin
        r_op_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_wr  <= 1'b0;
      r_dir_wra <= '0;
      r_di      <= '0;
    end else begin
      r_reg_wr <= w_wb;
      if (w_wb) begin
        r_dir_wra <= bus.wb_dir;
        r_di      <= bus.wb_data;
      end
    end
  end

  assign bus.rq_ready = w_ready & rst_n;
  assign bus.op_valid = r_op_valid;
  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.op_rd    = r_op_rd;
  assign bus.dir_a    = r_dir_a;
  assign bus.dir_b    = r_dir_b;
  assign bus.reg_rd   = r_reg_rd;
  assign bus.dir_wra  = r_dir_wra;
  assign bus.di       = r_di;
  assign bus.reg_wr   = r_reg_wr;

endmodule

// File: tb/tb_reg_port_ctrl.sv
// tb_reg_port_ctrl: directed scoreboard bench with a behavioural bank
// (posedge write, negedge read). Honours WB_BYPASS_EN for stall timing.
module tb_reg_port_ctrl;
  import reg_port_ctrl_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int REL_K = 1;
`else
  localparam int REL_K = 2;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_port_ctrl_if bus ();

  reg_port_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        q[$];
  logic [31:0] mem   [32];
  logic [31:0] model [32];
  logic        mem_init = 1'b0;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] seed(input int r);
    return (r == 0) ? 32'hBAD0_0000 : (32'hA5A5_0000 + 32'(r));
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= seed(i);
      mem_init <= 1'b1;
    end else if (bus.reg_wr) begin
      mem[bus.dir_wra] <= bus.di;
    end
  end

  always @(negedge clk) begin
    if (bus.reg_rd) begin
      bus.doa <= mem[bus.dir_a];
      bus.dob <= mem[bus.dir_b];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [4:0] rd);
    exp_t e;
    e.a  = (rs == 5'd0) ? 32'd0 : model[rs];
    e.b  = (rt == 5'd0) ? 32'd0 : model[rt];
    e.rd = rd;
    q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_queue"}, 32'(q.size()), 32'd1);
      return;
    end
    e = q.pop_front();
    check({tag, "_a"}, bus.op_a, e.a);
    check({tag, "_b"}, bus.op_b, e.b);
    check({tag, "_rd"}, 32'(bus.op_rd), 32'(e.rd));
  endtask

  task automatic req(input logic [4:0] rs,
                     input logic [4:0] rt,
                     input logic [4:0] rd,
                     input logic       wb,
                     output int        stalls);
    bus.rq_valid = 1'b1;
    bus.rq_rs    = rs;
    bus.rq_rt    = rt;
    bus.rq_rd    = rd;
    bus.rq_wb    = wb;
    stalls = 0;
    #1;
    while (bus.rq_ready !== 1'b1 && stalls < 20) begin
      cyc();
      #1;
      stalls++;
    end
    check("req_accept", 32'(bus.rq_ready), 32'd1);
    if (bus.rq_ready === 1'b1) push(rs, rt, rd);
    cyc();
    bus.rq_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    int k;
    k = 0;
    bus.op_ready = 1'b1;
    #1;
    while (bus.op_valid !== 1'b1 && k < 20) begin
      cyc();
      #1;
      k++;
    end
    check({tag, "_valid"}, 32'(bus.op_valid), 32'd1);
    if (bus.op_valid === 1'b1) pop_check(tag);
    cyc();
    bus.op_ready = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_dir   = r;
    bus.wb_data  = d;
    if (r != 5'd0) model[r] = d;
    cyc();
    bus.wb_valid = 1'b0;
    check("wb_reg_wr", 32'(bus.reg_wr), (r != 5'd0) ? 32'd1 : 32'd0);
    if (r != 5'd0) begin
      check("wb_dir_wra", 32'(bus.dir_wra), 32'(r));
      check("wb_di", bus.di, d);
    end
    cyc();
    check("wb_pulse_end", 32'(bus.reg_wr), 32'd0);
  endtask

  task automatic stall_release(input string tag,
                               input logic [4:0] r,
                               input logic [31:0] d,
                               output int k);
    bus.wb_valid = 1'b1;
    bus.wb_dir   = r;
    bus.wb_data  = d;
    model[r] = d;
    k = 0;
    while (bus.rq_ready !== 1'b1 && k < 10) begin
      cyc();
      bus.wb_valid = 1'b0;
      #1;
      k++;
    end
    check(tag, 32'(k), 32'(REL_K));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;
    for (int i = 0; i < 32; i++) model[i] = seed(i);
    rst_n        = 1'b0;
    bus.rq_valid = 1'b0;
    bus.rq_rs    = '0;
    bus.rq_rt    = '0;
    bus.rq_rd    = '0;
    bus.rq_wb    = 1'b0;
    bus.op_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_dir   = '0;
    bus.wb_data  = '0;

    repeat (2) @(negedge clk);
    check("rst_rq_ready", 32'(bus.rq_ready), 32'd0);
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_reg_rd", 32'(bus.reg_rd), 32'd0);
    check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
    check("rst_op_a", bus.op_a, 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_rq_ready", 32'(bus.rq_ready), 32'd1);
    @(negedge clk);

    // latency: op_valid one edge after accept
    wb(5'd5, 32'hDEADBEEF);
    req(5'd5, 5'd0, 5'd1, 1'b0, s);
    check("lat_nostall", 32'(s), 32'd0);
    check("lat_reg_rd", 32'(bus.reg_rd), 32'd1);
    check("lat_dir_a", 32'(bus.dir_a), 32'd5);
    check("lat_not_yet", 32'(bus.op_valid), 32'd0);
    cyc();
    check("lat_valid", 32'(bus.op_valid), 32'd1);
    check("lat_rd_drop", 32'(bus.reg_rd), 32'd0);
    take("lat");

    // RAW stall on r7
    req(5'd1, 5'd2, 5'd7, 1'b1, s);
    take("raw_setup");
    bus.rq_valid = 1'b1;
    bus.rq_rs    = 5'd7;
    bus.rq_rt    = 5'd0;
    bus.rq_rd    = 5'd0;
    bus.rq_wb    = 1'b0;
    #1;
    check("raw_stall0", 32'(bus.rq_ready), 32'd0);
    cyc();
    #1;
    check("raw_stall1", 32'(bus.rq_ready), 32'd0);
    stall_release("raw_release_edge", 5'd7, 32'h12345678, k);
    if (bus.rq_ready === 1'b1) push(5'd7, 5'd0, 5'd0);
    cyc();
    bus.rq_valid = 1'b0;
    take("raw");

    // back-pressure in HOLD
    req(5'd5, 5'd7, 5'd4, 1'b0, s);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(bus.op_valid), 32'd1);
      check("hold_a", bus.op_a, 32'hDEADBEEF);
      check("hold_b", bus.op_b, 32'h12345678);
      check("hold_rd", 32'(bus.op_rd), 32'd4);
      check("hold_rq_ready", 32'(bus.rq_ready), 32'd0);
      cyc();
    end
    take("hold");
    check("hold_one_xfer", 32'(bus.op_valid), 32'd0);

    // back-to-back: HOLD+accept goes straight to READ
    req(5'd1, 5'd2, 5'd5, 1'b0, s);
    bus.op_ready = 1'b1;
    bus.rq_valid = 1'b1;
    bus.rq_rs    = 5'd3;
    bus.rq_rt    = 5'd4;
    bus.rq_rd    = 5'd6;
    bus.rq_wb    = 1'b0;
    #1;
    check("tp_read_busy", 32'(bus.rq_ready), 32'd0);
    cyc();
    #1;
    check("tp_valid_a", 32'(bus.op_valid), 32'd1);
    check("tp_ready", 32'(bus.rq_ready), 32'd1);
    pop_check("tp_a");
    push(5'd3, 5'd4, 5'd6);
    cyc();
    bus.rq_valid = 1'b0;
    #1;
    check("tp_gap", 32'(bus.op_valid), 32'd0);
    check("tp_reg_rd", 32'(bus.reg_rd), 32'd1);
    cyc();
    #1;
    check("tp_valid_b", 32'(bus.op_valid), 32'd1);
    pop_check("tp_b");
    cyc();
    bus.op_ready = 1'b0;

    // r0 writes are dropped and r0 reads return zero
    wb(5'd0, 32'hFFFFFFFF);
    req(5'd0, 5'd5, 5'd2, 1'b0, s);
    take("r0");

    // WAW stall on r3
    req(5'd1, 5'd2, 5'd3, 1'b1, s);
    take("waw_setup");
    bus.rq_valid = 1'b1;
    bus.rq_rs    = 5'd1;
    bus.rq_rt    = 5'd2;
    bus.rq_rd    = 5'd3;
    bus.rq_wb    = 1'b1;
    #1;
    check("waw_stall0", 32'(bus.rq_ready), 32'd0);
    cyc();
    #1;
    check("waw_stall1", 32'(bus.rq_ready), 32'd0);
    stall_release("waw_release_edge", 5'd3, 32'hCAFEF00D, k);
    if (bus.rq_ready === 1'b1) push(5'd1, 5'd2, 5'd3);
    cyc();
    bus.rq_valid = 1'b0;
    take("waw");
    wb(5'd3, 32'h0BADF00D);

    // reset while holding operands with r9 busy
    req(5'd1, 5'd2, 5'd9, 1'b1, s);
    cyc();
    check("pre_rst_valid", 32'(bus.op_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.op_valid), 32'd0);
    check("rst_async_ready", 32'(bus.rq_ready), 32'd0);
    check("rst_async_rd", 32'(bus.reg_rd), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    req(5'd9, 5'd0, 5'd8, 1'b0, s);
    check("post_rst_nostall", 32'(s), 32'd0);
    take("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
